// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU with valid/ready handshake, tag pass-through and sticky overflow.
// Define ALU_PIPE_INREG_EN to add the S1 input register (latency 2 instead of 1).
module alu_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_opcode,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_ne,
  output logic               out_lt,
  output logic               out_ovf,
  output logic [TAG_W-1:0]   out_tag,
  output logic               ovf_sticky,
  input  logic               ovf_clear
);
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_SLT = 5'b00110;
  localparam int MSB = WIDTH - 1;

  logic               s2_load;
  logic               x_valid;
  logic [4:0]         x_op;
  logic [SHAMT_W-1:0] x_shamt;
  logic [WIDTH-1:0]   x_a;
  logic [WIDTH-1:0]   x_b;
  logic [TAG_W-1:0]   x_tag;

`ifdef ALU_PIPE_INREG_EN
  logic               s1_valid_q, s1_valid_d;
  logic [4:0]         s1_op_q, s1_op_d;
  logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
  logic [WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [WIDTH-1:0]   s1_b_q, s1_b_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

  // S1 frees up whenever S2 can take its beat, so a full pipe accepts on the output handshake edge.
  always_comb begin
    in_ready   = !reset && (!s1_valid_q || s2_load);
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_shamt_d = s1_shamt_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    if (in_ready && in_valid) begin
      s1_op_d    = in_opcode;
      s1_shamt_d = in_shamt;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_tag_d   = in_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_shamt_q <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_shamt_q <= s1_shamt_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  assign x_valid = s1_valid_q;
  assign x_op    = s1_op_q;
  assign x_shamt = s1_shamt_q;
  assign x_a     = s1_a_q;
  assign x_b     = s1_b_q;
  assign x_tag   = s1_tag_q;
`else
  assign in_ready = !reset && s2_load;
  assign x_valid  = in_valid && in_ready;
  assign x_op     = in_opcode;
  assign x_shamt  = in_shamt;
  assign x_a      = in_a;
  assign x_b      = in_b;
  assign x_tag    = in_tag;
`endif

  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               ne_q, ne_d;
  logic               lt_q, lt_d;
  logic               ovf_q, ovf_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               sticky_q, sticky_d;
  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               ovf_add, ovf_sub, lt_c, alu_ovf;

  always_comb begin
    sum     = x_a + x_b;
    diff    = x_a + ~x_b + WIDTH'(1);
    ovf_add = (x_a[MSB] == x_b[MSB]) && (sum[MSB] != x_a[MSB]);
    ovf_sub = (x_a[MSB] == !x_b[MSB]) && (diff[MSB] != x_a[MSB]);
    // Signed compare stays exact when diff overflows: differing signs decide it directly.
    lt_c    = (x_a[MSB] & ~x_b[MSB]) | (~(x_a[MSB] ^ x_b[MSB]) & diff[MSB]);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (x_op)
      OP_ADD: begin alu_res = sum;  alu_ovf = ovf_add; end
      OP_SUB: begin alu_res = diff; alu_ovf = ovf_sub; end
      OP_AND: alu_res = x_a & x_b;
      OP_OR:  alu_res = x_a | x_b;
      OP_SLL: alu_res = x_a << x_shamt;
      OP_SRA: alu_res = $signed(x_a) >>> x_shamt;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt_c};
      default: ;
    endcase
  end

  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    s2_valid_d = s2_load ? x_valid : s2_valid_q;
    res_d      = res_q;
    ne_d       = ne_q;
    lt_d       = lt_q;
    ovf_d      = ovf_q;
    tag_d      = tag_q;
    if (s2_load && x_valid) begin
      res_d = alu_res;
      ne_d  = |diff;
      lt_d  = lt_c;
      ovf_d = alu_ovf;
      tag_d = x_tag;
    end
    // A set on this edge's handshake beats a simultaneous clear.
    if (s2_valid_q && out_ready && ovf_q) sticky_d = 1'b1;
    else if (ovf_clear)                   sticky_d = 1'b0;
    else                                  sticky_d = sticky_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      ne_q       <= 1'b0;
      lt_q       <= 1'b0;
      ovf_q      <= 1'b0;
      tag_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      ne_q       <= ne_d;
      lt_q       <= lt_d;
      ovf_q      <= ovf_d;
      tag_q      <= tag_d;
      sticky_q   <= sticky_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = res_q;
  assign out_ne     = ne_q;
  assign out_lt     = lt_q;
  assign out_ovf    = ovf_q;
  assign out_tag    = tag_q;
  assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed checks of alu_pipe against a signed-arithmetic reference model.
// Follows ALU_PIPE_INREG_EN for the expected latency; ALU_PIPE_TB_W16 selects a 16-bit datapath.
`timescale 1ns/1ps
module tb_alu_pipe;
`ifdef ALU_PIPE_TB_W16
  localparam int W = 16;
`else
  localparam int W = 32;
`endif
  localparam int SW = $clog2(W);
  localparam int TW = 4;
`ifdef ALU_PIPE_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [W-1:0] MSB_V = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXP  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ALL1  = {W{1'b1}};
  localparam logic [W-1:0] ONE   = W'(1);

  typedef struct packed {
    logic [W-1:0]  res;
    logic          ne;
    logic          lt;
    logic          ovf;
    logic [TW-1:0] tag;
  } beat_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, out_ne, out_lt, out_ovf;
  logic ovf_sticky, ovf_clear;
  logic [4:0]    in_opcode;
  logic [SW-1:0] in_shamt;
  logic [W-1:0]  in_a, in_b, out_result;
  logic [TW-1:0] in_tag, out_tag;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .SHAMT_W(SW), .TAG_W(TW)) dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_shamt(in_shamt), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_ne(out_ne),
    .out_lt(out_lt), .out_ovf(out_ovf), .out_tag(out_tag), .ovf_sticky(ovf_sticky),
    .ovf_clear(ovf_clear)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: operands as signed integers, overflow means the true result leaves the W-bit range.
  function automatic beat_t model(input logic [4:0] op, input logic [SW-1:0] sh,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [TW-1:0] tag);
    beat_t r;
    longint sa, sb, s, hi, lo;
    sa = $signed({{(64-W){a[W-1]}}, a});
    sb = $signed({{(64-W){b[W-1]}}, b});
    hi = (longint'(1) <<< (W-1)) - 1;
    lo = -(longint'(1) <<< (W-1));
    r = '0;
    r.tag = tag;
    r.ne  = (a != b);
    r.lt  = (sa < sb);
    case (op)
      5'd0: begin s = sa + sb; r.res = s[W-1:0]; r.ovf = (s > hi) || (s < lo); end
      5'd1: begin s = sa - sb; r.res = s[W-1:0]; r.ovf = (s > hi) || (s < lo); end
      5'd2: r.res = a & b;
      5'd3: r.res = a | b;
      5'd4: r.res = a << sh;
      5'd5: begin s = sa >>> sh; r.res = s[W-1:0]; end
      5'd6: r.res = W'(r.lt);
      default: ;
    endcase
    return r;
  endfunction

  beat_t exp_q[$];
  beat_t last_b, prev_out, e;
  logic [W-1:0] obs_res[$];
  logic sticky_m = 1'b0;
  logic stall_prev = 1'b0;

  // Monitor: checks each output handshake against the scoreboard, stall stability, in_ready and sticky.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      sticky_m   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("sticky", 64'(ovf_sticky), 64'(sticky_m));
      chk("in_ready", 64'(in_ready), 64'(!(exp_q.size() >= LAT && !out_ready)));
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'({out_result, out_ne, out_lt, out_ovf, out_tag}), 64'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'(out_result), 64'(e.res));
          chk("flags", 64'({out_ne, out_lt, out_ovf}), 64'({e.ne, e.lt, e.ovf}));
          chk("tag", 64'(out_tag), 64'(e.tag));
          last_b = {out_result, out_ne, out_lt, out_ovf, out_tag};
          obs_res.push_back(out_result);
          if (e.ovf) sticky_m = 1'b1;
          else if (ovf_clear) sticky_m = 1'b0;
        end
      end else if (ovf_clear) begin
        sticky_m = 1'b0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_opcode, in_shamt, in_a, in_b, in_tag));
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_result, out_ne, out_lt, out_ovf, out_tag};
    end
  end

  task automatic send(input logic [4:0] op, input logic [SW-1:0] sh, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [TW-1:0] tag);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; in_opcode = op; in_shamt = sh; in_a = a; in_b = b; in_tag = tag;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else if (t == 49) chk("accept_timeout", 64'(in_ready), 64'(1));
      if (!got) @(posedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0: return MSB_V;
      1: return MAXP;
      2: return '0;
      3: return ALL1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic v, acc;
    logic [W-1:0] sra_in, sra_exp;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; ovf_clear = 1'b0;
    in_opcode = 5'd0; in_shamt = '0; in_a = ONE; in_b = ONE; in_tag = 4'd1;

    // Reset held three cycles with a valid input pending.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out", 64'({out_valid, out_result, out_ne, out_lt, out_ovf, out_tag, ovf_sticky}), 64'(0));
      @(posedge clk); #1;
    end
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;

    // Latency: accept edge to output handshake edge.
    send(5'd0, '0, W'(3), W'(4), 4'd1);
    lat = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); v = out_valid;
      @(posedge clk); lat++;
      if (v) break;
    end
    #1;
    chk("latency", 64'(lat), 64'(LAT));
    chk("add_res", 64'(last_b.res), 64'(7));

    // SUB overflow and sticky set.
    send(5'd1, '0, MSB_V, ONE, 4'd3);
    drain();
    chk("sub_res", 64'(last_b.res), 64'(MAXP));
    chk("sub_flags", 64'({last_b.ne, last_b.lt, last_b.ovf}), 64'(3'b111));
    chk("sub_tag", 64'(last_b.tag), 64'(3));
    chk("sticky_set", 64'(ovf_sticky), 64'(1));

    // Second overflow beat handshakes on the same edge as ovf_clear.
    out_ready = 1'b0;
    send(5'd0, '0, MAXP, ONE, 4'd5);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    @(posedge clk); #1;
    out_ready = 1'b1; ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    chk("sticky_set_wins", 64'(ovf_sticky), 64'(1));
    chk("add_ovf_res", 64'({last_b.res, last_b.ovf}), 64'({MSB_V, 1'b1}));
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    chk("sticky_clear", 64'(ovf_sticky), 64'(0));

    // Shifts and SLT.
    sra_in  = {4'hF, {(W-4){1'b0}}};
    sra_exp = {8'hFF, {(W-8){1'b0}}};
    send(5'd5, SW'(4), sra_in, '0, 4'd6);
    drain();
    chk("sra", 64'({last_b.res, last_b.ovf}), 64'({sra_exp, 1'b0}));
    send(5'd4, SW'(W-1), ONE, '0, 4'd7);
    drain();
    chk("sll", 64'({last_b.res, last_b.ovf}), 64'({MSB_V, 1'b0}));
    send(5'd6, '0, ALL1, ONE, 4'd8);
    drain();
    chk("slt", 64'({last_b.res, last_b.ovf}), 64'({ONE, 1'b0}));

    // Unknown opcode with equal operands.
    send(5'b11111, '0, W'(5), W'(5), 4'd9);
    drain();
    chk("unk_res", 64'(last_b.res), 64'(0));
    chk("unk_flags", 64'({last_b.ne, last_b.lt, last_b.ovf}), 64'(0));
    chk("unk_tag", 64'(last_b.tag), 64'(9));

    // Backpressure mid-stream.
    obs_res.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) send(5'd0, '0, W'(i), W'(10), TW'(i));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(obs_res.size()), 64'(4));
    for (int i = 0; i < 4 && i < obs_res.size(); i++)
      chk("bp_order", 64'(obs_res[i]), 64'(10 + i));

    // Reset with the pipeline full: nothing may emerge afterwards.
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) send(5'd0, '0, W'(i), ONE, TW'(i));
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flushed", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;

    // Randomized traffic with random stalls and clears.
    acc = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!in_valid || acc) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_opcode = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 6)) : 5'($urandom_range(7, 31));
        in_shamt  = SW'($urandom);
        in_a      = rand_val();
        in_b      = rand_val();
        in_tag    = TW'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clear = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; ovf_clear = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
